// File: rtl/bus_master_pkg.sv
// Shared types and constants for the bus traffic-generator master.
package bus_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WGAP,
    WR,
    RGAP,
    RD,
    DONE
  } state_t;

  localparam int MODE_WR_ONLY  = 0;
  localparam int MODE_WR_CHECK = 1;

  localparam int IDLE_VAL_DEF  = 99;

endpackage

// File: rtl/bus_master_chk.sv
// Read-back checker: saturating mismatch counter, plus first-error capture
// when BUS_MASTER_FIRST_ERR_EN is defined.
module bus_master_chk #(
  parameter int DATA_W = 8,
  parameter int ERR_W  = 8
`ifdef BUS_MASTER_FIRST_ERR_EN
  ,
  parameter int ADDR_W = 8
`endif
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              clr,
  input  logic              cmp_en,
  input  logic [DATA_W-1:0] expected,
  input  logic [DATA_W-1:0] readdata,
`ifdef BUS_MASTER_FIRST_ERR_EN
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_data,
  output logic              err_valid,
`endif
  output logic [ERR_W-1:0]  err_cnt
);

  logic mismatch;

  assign mismatch = cmp_en && (readdata != expected);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (clr) begin
      err_cnt <= '0;
    end else if (mismatch && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

`ifdef BUS_MASTER_FIRST_ERR_EN
  // Only the first mismatch of a pass is kept; later ones leave it alone.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      err_addr  <= '0;
      err_data  <= '0;
      err_valid <= 1'b0;
    end else if (clr) begin
      err_addr  <= '0;
      err_data  <= '0;
      err_valid <= 1'b0;
    end else if (mismatch && !err_valid) begin
      err_addr  <= addr;
      err_data  <= readdata;
      err_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/bus_master_gen.sv
// Traffic-generator bus master: incrementing write pass, optional read-back
// check pass. BUS_MASTER_FIRST_ERR_EN adds first-mismatch capture outputs.
module bus_master_gen
  import bus_master_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int NUM_XFERS = 16,
  parameter int GAP       = 1,
  parameter int MODE      = MODE_WR_ONLY,
  parameter int BASE_ADDR = 0,
  parameter int BASE_DATA = 0,
  parameter int IDLE_VAL  = IDLE_VAL_DEF,
  parameter int ERR_W     = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic              waitrequest,
  input  logic [DATA_W-1:0] readdata,
  output logic [ADDR_W-1:0] address,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  output logic              read,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  err_cnt
`ifdef BUS_MASTER_FIRST_ERR_EN
  ,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_data,
  output logic              err_valid
`endif
);

  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_XFERS - 1);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [DATA_W-1:0] BASE_D   = DATA_W'(BASE_DATA);
  localparam logic [ADDR_W-1:0] IDLE_A   = ADDR_W'(IDLE_VAL);
  localparam logic [DATA_W-1:0] IDLE_D   = DATA_W'(IDLE_VAL);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic              clr;
  logic              cmp_en;
  logic [DATA_W-1:0] cur_data;

  assign cur_data = BASE_D + DATA_W'(idx);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  // Gap counter reloads outside the gap states, so it is always full on entry.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    gap_nxt   = GAP_LOAD;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clr       = 1'b1;
          idx_nxt   = '0;
          state_nxt = (GAP > 0) ? WGAP : WR;
        end
      end
      WGAP: begin
        if (gap_cnt == '0) state_nxt = WR;
        else               gap_nxt   = gap_cnt - GAP_W'(1);
      end
      WR: begin
        if (!waitrequest) begin
          if (idx == LAST_IDX) begin
            idx_nxt = '0;
            if (MODE == MODE_WR_CHECK) state_nxt = (GAP > 0) ? RGAP : RD;
            else                       state_nxt = DONE;
          end else begin
            idx_nxt   = idx + ADDR_W'(1);
            state_nxt = (GAP > 0) ? WGAP : WR;
          end
        end
      end
      RGAP: begin
        if (gap_cnt == '0) state_nxt = RD;
        else               gap_nxt   = gap_cnt - GAP_W'(1);
      end
      RD: begin
        if (!waitrequest) begin
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + ADDR_W'(1);
            state_nxt = (GAP > 0) ? RGAP : RD;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    address   = IDLE_A;
    writedata = IDLE_D;
    write     = 1'b0;
    read      = 1'b0;
    case (state)
      WR: begin
        write     = 1'b1;
        address   = BASE_A + idx;
        writedata = cur_data;
      end
      RD: begin
        read    = 1'b1;
        address = BASE_A + idx;
      end
      default: ;
    endcase
  end

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign cmp_en = (state == RD) && !waitrequest;

  bus_master_chk #(
    .DATA_W (DATA_W),
    .ERR_W  (ERR_W)
`ifdef BUS_MASTER_FIRST_ERR_EN
    ,
    .ADDR_W (ADDR_W)
`endif
  ) u_chk (
    .CLK       (CLK),
    .reset     (reset),
    .clr       (clr),
    .cmp_en    (cmp_en),
    .expected  (cur_data),
    .readdata  (readdata),
`ifdef BUS_MASTER_FIRST_ERR_EN
    .addr      (address),
    .err_addr  (err_addr),
    .err_data  (err_data),
    .err_valid (err_valid),
`endif
    .err_cnt   (err_cnt)
  );

endmodule

// File: tb/tb_bus_master_gen.sv
// Scoreboard bench for bus_master_gen with a memory-model slave, random stalls
// and random read-data corruption.
module tb_bus_master_gen;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int NUM_XFERS = 8;
  localparam int GAP       = 1;
  localparam int MODE      = 1;
  localparam int BASE_ADDR = 252;
  localparam int BASE_DATA = 250;
  localparam int IDLE_VAL  = 99;
  localparam int ERR_W     = 2;
  localparam int RUN_CYC   = 1 + NUM_XFERS * (GAP + 1) * (MODE + 1);

  logic              CLK = 1'b0;
  logic              reset;
  logic              start;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic [ADDR_W-1:0] address;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              read;
  logic              busy;
  logic              done;
  logic [ERR_W-1:0]  err_cnt;
`ifdef BUS_MASTER_FIRST_ERR_EN
  logic [ADDR_W-1:0] err_addr;
  logic [DATA_W-1:0] err_data;
  logic              err_valid;
`endif

  bus_master_gen #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .NUM_XFERS (NUM_XFERS),
    .GAP       (GAP),
    .MODE      (MODE),
    .BASE_ADDR (BASE_ADDR),
    .BASE_DATA (BASE_DATA),
    .IDLE_VAL  (IDLE_VAL),
    .ERR_W     (ERR_W)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .start       (start),
    .waitrequest (waitrequest),
    .readdata    (readdata),
    .address     (address),
    .write       (write),
    .writedata   (writedata),
    .read        (read),
    .busy        (busy),
    .done        (done),
    .err_cnt     (err_cnt)
`ifdef BUS_MASTER_FIRST_ERR_EN
    ,
    .err_addr    (err_addr),
    .err_data    (err_data),
    .err_valid   (err_valid)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int kind;    // 0 write, 1 read, 2 done
    int addr;
    int data;
    int err;
    int faddr;
    int fdata;
    int fvalid;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   wait_mode = 0;
  logic [NUM_XFERS-1:0] corrupt = '0;
  logic [DATA_W-1:0] mem [256];
  bit   mon_en = 1'b0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   cyc = 0;
  int   last_err = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  // Slave: decides the stall for the coming edge, stores accepted writes,
  // returns memory contents (inverted where the run corrupts that index).
  initial begin
    waitrequest = 1'b0;
    readdata    = '0;
    forever begin
      @(negedge CLK);
      #1;
      case (wait_mode)
        0:       waitrequest = 1'b0;
        1:       waitrequest = ($urandom_range(0, 2) == 0);
        default: waitrequest = 1'b1;
      endcase
      if (write && !waitrequest) mem[address] = writedata;
      readdata = mem[address];
      if (read) begin
        int ix;
        ix = (int'(address) - BASE_ADDR + 256) % 256;
        if (ix < NUM_XFERS && corrupt[ix]) readdata = ~readdata;
      end
    end
  end

  // Monitor: compares every bus completion and done pulse against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      cyc++;
      if (mon_en) begin
        check("rw_exclusive", int'(write & read), 0);
        if ((write || read) && !waitrequest || done) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow actual write=%0d read=%0d done=%0d required none", write, read, done);
          end else begin
            e = sb.pop_front();
            if (done) begin
              check("done_kind", 2, e.kind);
              check("done_err_cnt", int'(err_cnt), e.err);
              check("done_busy", int'(busy), 1);
`ifdef BUS_MASTER_FIRST_ERR_EN
              check("err_valid", int'(err_valid), e.fvalid);
              if (e.fvalid != 0) begin
                check("err_addr", int'(err_addr), e.faddr);
                check("err_data", int'(err_data), e.fdata);
              end
`endif
              done_cnt++;
              done_cyc = cyc;
            end else if (write) begin
              check("wr_kind", 0, e.kind);
              check("wr_addr", int'(address), e.addr);
              check("wr_data", int'(writedata), e.data);
            end else begin
              check("rd_kind", 1, e.kind);
              check("rd_addr", int'(address), e.addr);
            end
          end
        end
        if (!write && !read) begin
          check("idle_addr", int'(address), IDLE_VAL);
          check("idle_wdata", int'(writedata), IDLE_VAL);
        end
        if (read) check("rd_wdata_idle", int'(writedata), IDLE_VAL);
      end
    end
  end

  // Reference: plain arithmetic over the transfer index.
  task automatic push_run(input logic [NUM_XFERS-1:0] mask);
    exp_t e;
    int   nerr;
    nerr     = 0;
    e.err    = 0;
    e.faddr  = 0;
    e.fdata  = 0;
    e.fvalid = 0;
    for (int i = 0; i < NUM_XFERS; i++) begin
      e.kind = 0;
      e.addr = (BASE_ADDR + i) % 256;
      e.data = (BASE_DATA + i) % 256;
      sb.push_back(e);
    end
    if (MODE == 1) begin
      for (int i = 0; i < NUM_XFERS; i++) begin
        e.kind = 1;
        e.addr = (BASE_ADDR + i) % 256;
        e.data = (BASE_DATA + i) % 256;
        sb.push_back(e);
        if (mask[i]) begin
          nerr++;
          if (e.fvalid == 0) begin
            e.fvalid = 1;
            e.faddr  = e.addr;
            e.fdata  = 255 - e.data;
          end
        end
      end
    end
    e.kind   = 2;
    e.err    = (nerr > (1 << ERR_W) - 1) ? (1 << ERR_W) - 1 : nerr;
    last_err = e.err;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int d0, input string name);
    for (int k = 0; k < 3000 && done_cnt == d0; k++) @(negedge CLK);
    check(name, int'(done_cnt != d0), 1);
  endtask

  task automatic run(input int wmode, input logic [NUM_XFERS-1:0] mask, output int cycles);
    int d0;
    int t0;
    wait_mode = wmode;
    corrupt   = mask;
    push_run(mask);
    @(negedge CLK);
    start = 1'b1;
    d0    = done_cnt;
    t0    = cyc;
    @(negedge CLK);
    start = 1'b0;
    repeat (3) @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_done(d0, "done_timeout");
    cycles = done_cyc - t0 - 1;
    #3;
    check("idle_after_done", int'(busy), 0);
    @(negedge CLK);
    #3;
    check("err_cnt_hold", int'(err_cnt), last_err);
  endtask

  initial begin
    int cycles;
    int d0;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    #1;
    check("rst_write", int'(write), 0);
    check("rst_read", int'(read), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_addr", int'(address), IDLE_VAL);
    check("rst_wdata", int'(writedata), IDLE_VAL);
    check("rst_err_cnt", int'(err_cnt), 0);
    repeat (3) @(negedge CLK);
    reset  = 1'b0;
    mon_en = 1'b1;

    run(0, '0, cycles);
    check("cycle_count_clean", cycles, RUN_CYC);

    for (int r = 0; r < 5; r++) run(1, NUM_XFERS'($urandom), cycles);

    run(1, NUM_XFERS'(8'b0010_0000), cycles);
    check("single_err", int'(err_cnt), 1);

    run(0, '1, cycles);
    check("saturated_err", int'(err_cnt), (1 << ERR_W) - 1);
    check("cycle_count_err", cycles, RUN_CYC);

    run(1, '0, cycles);
    check("err_cleared", int'(err_cnt), 0);

    // start held high: second run begins right after the idle cycle
    wait_mode = 1;
    corrupt   = '0;
    push_run('0);
    push_run('0);
    @(negedge CLK);
    start = 1'b1;
    d0    = done_cnt;
    wait_done(d0, "retrig_done1_timeout");
    #3;
    check("retrig_idle", int'(busy), 0);
    @(negedge CLK);
    start = 1'b0;
    #3;
    check("retrig_busy", int'(busy), 1);
    wait_done(d0 + 1, "retrig_done2_timeout");

    // asynchronous reset while a write is stalled
    mon_en    = 1'b0;
    wait_mode = 2;
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int k = 0; k < 20 && !write; k++) @(negedge CLK);
    #3;
    check("stall_write", int'(write), 1);
    reset = 1'b1;
    #1;
    check("arst_write", int'(write), 0);
    check("arst_read", int'(read), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_addr", int'(address), IDLE_VAL);
    check("arst_wdata", int'(writedata), IDLE_VAL);
    @(negedge CLK);
    reset = 1'b0;
    sb.delete();
    mon_en = 1'b1;
    run(1, NUM_XFERS'($urandom), cycles);

    check("sb_leftover", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
